// File: rtl/inv_round_counter_a_if.sv
// Control bundle between the inverse-cipher datapath controller and the round sequencer.
// The master drives start/key length/stall/abort; the sequencer answers with the round strobes and status.
interface inv_round_counter_a_if #(
  parameter int ROUND_W = 5
);
  logic               i_start;
  logic [1:0]         i_key_len;
  logic               i_stall;
  logic               i_abort;
  logic [ROUND_W-1:0] o_round;
  logic               o_round_valid;
  logic               o_last_round;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_key_len, i_stall, i_abort,
    input  o_round, o_round_valid, o_last_round, o_busy, o_done
  );

  modport slave (
    input  i_start, i_key_len, i_stall, i_abort,
    output o_round, o_round_valid, o_last_round, o_busy, o_done
  );
endinterface

// File: rtl/inv_round_counter_a.sv
// AES inverse-cipher round sequencer: counts the round-key index down from Nr to 0,
// one strobe per CYCLES_PER_ROUND cycles, with start/busy/done, stall and abort.
module inv_round_counter_a #(
  parameter int CYCLES_PER_ROUND = 2,
  parameter int ROUND_W          = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  inv_round_counter_a_if.slave bus
);

  generate
    if (CYCLES_PER_ROUND < 1 || CYCLES_PER_ROUND > 4 || ROUND_W < 4) begin : g_bad_params
      $error("inv_round_counter_a: CYCLES_PER_ROUND must be 1..4 and ROUND_W at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] PHASE_LAST = 2'(CYCLES_PER_ROUND - 1);

  state_t     state_reg, state_next;
  logic [1:0] phase_reg, phase_next;
  // The round register doubles as the latched Nr: it is loaded with Nr and only ever counts down.
  logic [3:0] round_reg, round_next;
  logic       valid_reg, valid_next;
  logic       last_reg,  last_next;
  logic       busy_reg,  busy_next;
  logic       done_reg,  done_next;
  logic [3:0] nr_decoded;

  always_comb begin
    case (bus.i_key_len)
      2'b01:   nr_decoded = 4'd12;
      2'b10:   nr_decoded = 4'd14;
      default: nr_decoded = 4'd10;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      round_reg <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      round_reg <= round_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    round_next = round_reg;
    valid_next = 1'b0;
    last_next  = 1'b0;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    if (bus.i_abort) begin
      state_next = IDLE;
      phase_next = '0;
      round_next = '0;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_start) begin
            state_next = RUN;
            phase_next = '0;
            round_next = nr_decoded;
            valid_next = 1'b1;
            busy_next  = 1'b1;
          end
        end
        RUN: begin
          if (!bus.i_stall) begin
            if (phase_reg == PHASE_LAST) begin
              phase_next = '0;
              round_next = round_reg - 4'd1;
              valid_next = 1'b1;
              // round_reg never reaches 0 inside RUN, so the decrement cannot wrap.
              if (round_reg == 4'd1) begin
                last_next  = 1'b1;
                state_next = DONE;
              end
            end else begin
              phase_next = phase_reg + 2'd1;
            end
          end
        end
        DONE: begin
          // DONE is the round-0 strobe cycle; the done pulse lands in the following (idle) cycle,
          // which is where a back-to-back start is accepted.
          state_next = IDLE;
          phase_next = '0;
          round_next = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
        default: begin
          state_next = IDLE;
          phase_next = '0;
          round_next = '0;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  assign bus.o_round[3:0]  = round_reg;
  assign bus.o_round_valid = valid_reg;
  assign bus.o_last_round  = last_reg;
  assign bus.o_busy        = busy_reg;
  assign bus.o_done        = done_reg;

  genvar gi;
  generate
    for (gi = 4; gi < ROUND_W; gi++) begin : g_round_upper
      assign bus.o_round[gi] = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_inv_round_counter_a.sv
// Bench for inv_round_counter_a: two instances (2 and 1 cycles per round) share one stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_inv_round_counter_a;
  localparam int RW = 5;
  localparam int OW = RW + 4;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  logic       start   = 1'b0;
  logic [1:0] key_len = 2'b00;
  logic       stall   = 1'b0;
  logic       abort   = 1'b0;

  inv_round_counter_a_if #(.ROUND_W(RW)) bus2 ();
  inv_round_counter_a_if #(.ROUND_W(RW)) bus1 ();

  assign bus2.i_start = start;  assign bus1.i_start = start;
  assign bus2.i_key_len = key_len; assign bus1.i_key_len = key_len;
  assign bus2.i_stall = stall;  assign bus1.i_stall = stall;
  assign bus2.i_abort = abort;  assign bus1.i_abort = abort;

  inv_round_counter_a #(.CYCLES_PER_ROUND(2), .ROUND_W(RW)) dut2 (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus2.slave));
  inv_round_counter_a #(.CYCLES_PER_ROUND(1), .ROUND_W(RW)) dut1 (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus1.slave));

  logic [OW-1:0] out2, out1;
  assign out2 = {bus2.o_round, bus2.o_round_valid, bus2.o_last_round, bus2.o_busy, bus2.o_done};
  assign out1 = {bus1.o_round, bus1.o_round_valid, bus1.o_last_round, bus1.o_busy, bus1.o_done};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: t counts unstalled cycles since the start edge; the round index is Nr - t/cpr.
  typedef struct {
    bit active;
    int nr;
    int t;
    bit strobe;
    bit done;
  } model_t;

  model_t m2, m1;

  function automatic model_t model_idle();
    model_t m;
    m.active = 0; m.nr = 0; m.t = 0; m.strobe = 0; m.done = 0;
    return m;
  endfunction

  function automatic model_t model_edge(model_t m, int cpr, bit st, logic [1:0] kl, bit sl, bit ab);
    model_t n;
    n = m;
    n.strobe = 0;
    n.done   = 0;
    if (ab) begin
      n.active = 0;
      n.t      = 0;
    end else if (m.active) begin
      if (m.t == m.nr * cpr) begin
        n.active = 0;
        n.done   = 1;
      end else if (!sl) begin
        n.t      = m.t + 1;
        n.strobe = (n.t % cpr) == 0;
      end
    end else if (st) begin
      n.active = 1;
      n.nr     = (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
      n.t      = 0;
      n.strobe = 1;
    end
    return n;
  endfunction

  function automatic logic [OW-1:0] model_out(model_t m, int cpr);
    logic [RW-1:0] r;
    logic          v;
    r = m.active ? RW'(m.nr - m.t / cpr) : '0;
    v = m.active && m.strobe;
    return {r, v, v && (r == '0), logic'(m.active), logic'(m.done)};
  endfunction

  task automatic check_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got round=%0d valid=%b last=%b busy=%b done=%b, expected round=%0d valid=%b last=%b busy=%b done=%b",
               name, act[OW-1:4], act[3], act[2], act[1], act[0], exp[OW-1:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance both models with the inputs seen at the edge, then compare both DUTs.
  task automatic step();
    @(posedge i_clk);
    m2 = model_edge(m2, 2, start, key_len, stall, abort);
    m1 = model_edge(m1, 1, start, key_len, stall, abort);
    #1;
    check_vec("model_cpr2", out2, model_out(m2, 2));
    check_vec("model_cpr1", out1, model_out(m1, 1));
  endtask

  task automatic clear();
    start = 0; stall = 0; abort = 1;
    step();
    abort = 0;
  endtask

  task automatic wait_strobe(input int rnd, output int edges);
    edges = -1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (bus2.o_round_valid && bus2.o_round == RW'(rnd)) begin
        edges = e;
        break;
      end
    end
    check_int("wait_strobe_found", (edges > 0) ? 1 : 0, 1);
  endtask

  task automatic run_op(input logic [1:0] kl, input int nr, input bit hold);
    int strobes, lasts, busy_n, d2, d1;
    strobes = 0; lasts = 0; busy_n = 0; d2 = -1; d1 = -1;
    clear();
    start = 1; key_len = kl;
    step();
    strobes += int'(bus2.o_round_valid);
    busy_n  += int'(bus2.o_busy);
    if (!hold) start = 0;
    for (int e = 1; e <= 40 && d2 < 0; e++) begin
      step();
      strobes += int'(bus2.o_round_valid);
      lasts   += int'(bus2.o_last_round);
      busy_n  += int'(bus2.o_busy);
      if (bus1.o_done && d1 < 0) d1 = e;
      if (bus2.o_done) d2 = e;
    end
    start = 0;
    $display("op key_len=%b hold=%0d: strobes=%0d done_cpr2=%0d done_cpr1=%0d busy=%0d",
             kl, hold, strobes, d2, d1, busy_n);
    check_int("strobe_count", strobes, nr + 1);
    check_int("last_round_count", lasts, 1);
    check_int("done_edge_cpr2", d2, 2 * nr + 1);
    check_int("done_edge_cpr1", d1, nr + 1);
    check_int("busy_cycles", busy_n, 2 * nr + 1);
  endtask

  typedef struct {
    logic          st;
    logic [1:0]    kl;
    logic          sl;
    logic          ab;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int e, r4, d2;

    // {start, key_len, stall, abort, {round, valid, last, busy, done}} for the 2-cycle instance
    vecs[0]  = '{1, 2'b00, 0, 0, {5'd10, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = '{0, 2'b00, 0, 0, {5'd10, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{0, 2'b00, 0, 0, {5'd9,  1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[3]  = '{1, 2'b10, 0, 0, {5'd9,  1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{0, 2'b00, 1, 0, {5'd9,  1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[5]  = '{0, 2'b00, 0, 0, {5'd8,  1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[6]  = '{1, 2'b00, 1, 1, {5'd0,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{1, 2'b01, 0, 1, {5'd0,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{0, 2'b00, 1, 0, {5'd0,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{1, 2'b11, 0, 0, {5'd10, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{0, 2'b00, 0, 1, {5'd0,  1'b0, 1'b0, 1'b0, 1'b0}};

    m2 = model_idle();
    m1 = model_idle();
    repeat (2) @(posedge i_clk);
    #1;
    check_vec("reset_cpr2", out2, '0);
    check_vec("reset_cpr1", out1, '0);
    @(negedge i_clk);
    i_reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start = vecs[i].st; key_len = vecs[i].kl; stall = vecs[i].sl; abort = vecs[i].ab;
      step();
      $display("vec %0d: out=%h expected=%h", i, out2, vecs[i].exp);
      check_vec($sformatf("vec%0d", i), out2, vecs[i].exp);
    end
    start = 0; stall = 0; abort = 0;

    run_op(2'b00, 10, 0);
    run_op(2'b10, 14, 0);
    run_op(2'b11, 10, 0);
    run_op(2'b01, 12, 1);

    // Stall for three cycles right after the round-5 strobe.
    clear();
    start = 1; key_len = 2'b00;
    step();
    start = 0;
    wait_strobe(5, e);
    check_int("round5_edge", e, 10);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_int("stall_round_hold", int'(bus2.o_round), 5);
      check_int("stall_no_strobe", int'(bus2.o_round_valid), 0);
    end
    stall = 0;
    e += 3; r4 = -1; d2 = -1;
    for (int i = 0; i < 30 && d2 < 0; i++) begin
      step();
      e++;
      if (bus2.o_round_valid && bus2.o_round == 5'd4 && r4 < 0) r4 = e;
      if (bus2.o_done) d2 = e;
    end
    $display("stall: round4 at edge %0d, done at edge %0d", r4, d2);
    check_int("stall_round4_edge", r4, 15);
    check_int("stall_done_edge", d2, 24);

    // Abort at round 6: no done pulse afterwards.
    clear();
    start = 1; key_len = 2'b00;
    step();
    start = 0;
    wait_strobe(6, e);
    abort = 1;
    step();
    abort = 0;
    check_vec("abort_clear", out2, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_int("abort_no_done", int'(bus2.o_done), 0);
    end
    $display("abort at round 6 done");

    // Reset at round 6 clears outputs immediately, then a fresh start runs normally.
    clear();
    start = 1; key_len = 2'b00;
    step();
    start = 0;
    wait_strobe(6, e);
    #2 i_reset = 1'b0;
    #1;
    check_vec("async_reset_cpr2", out2, '0);
    check_vec("async_reset_cpr1", out1, '0);
    m2 = model_idle();
    m1 = model_idle();
    @(negedge i_clk);
    i_reset = 1'b1;
    $display("reset at round 6 done");
    run_op(2'b00, 10, 0);

    // Back-to-back: start during the done cycle produces the Nr strobe on the next cycle.
    clear();
    start = 1; key_len = 2'b10;
    step();
    start = 0;
    d2 = -1;
    for (int i = 1; i <= 40 && d2 < 0; i++) begin
      step();
      if (bus2.o_done) d2 = i;
    end
    check_int("b2b_first_done", d2, 29);
    start = 1; key_len = 2'b00;
    step();
    start = 0;
    $display("back-to-back: round=%0d valid=%b busy=%b", bus2.o_round, bus2.o_round_valid, bus2.o_busy);
    check_vec("b2b_restart", out2, {5'd10, 1'b1, 1'b0, 1'b1, 1'b0});

    // Randomised traffic against the model.
    clear();
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      key_len = 2'($urandom_range(0, 3));
      stall   = ($urandom_range(0, 5) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      step();
    end
    start = 0; stall = 0; abort = 0;
    $display("random phase complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
